// File: rtl/exe_pkg.sv
// Shared constants and types for the execute stage: ALU command codes,
// shift types, NZCV bit positions and the multiplier FSM states.
package exe_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;
  localparam logic [3:0] CMD_MLA = 4'b1011;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_t;

endpackage

// File: rtl/exe_stage_mc_if.sv
// ID/EXE inputs, EXE/MEM outputs and the stall/freeze/flush controls of the execute stage.
interface exe_stage_mc_if #(
  parameter int unsigned DW = 32
);
  logic          valid_EXE;
  logic [DW-1:0] pc_EXE;
  logic [DW-1:0] rn_val_EXE;
  logic [DW-1:0] rm_val_EXE;
  logic [DW-1:0] rs_val_EXE;
  logic [23:0]   signed_imm_24_EXE;
  logic [11:0]   shifter_operand_EXE;
  logic [3:0]    exe_cmd_EXE;
  logic [3:0]    dest_EXE;
  logic          WB_EN_EXE;
  logic          MEM_R_EN_EXE;
  logic          MEM_W_EN_EXE;
  logic          S_EXE;
  logic          imm_EXE;
  logic          freeze;
  logic          flush;
  logic [DW-1:0] alu_res_MEM;
  logic [DW-1:0] rm_val_MEM;
  logic [3:0]    dest_MEM;
  logic          WB_EN_MEM;
  logic          MEM_R_EN_MEM;
  logic          MEM_W_EN_MEM;
  logic [3:0]    status_ID;
  logic [DW-1:0] branch_address_IF;
  logic          stall_EXE;

  modport master (
    output valid_EXE, pc_EXE, rn_val_EXE, rm_val_EXE, rs_val_EXE, signed_imm_24_EXE,
           shifter_operand_EXE, exe_cmd_EXE, dest_EXE, WB_EN_EXE, MEM_R_EN_EXE,
           MEM_W_EN_EXE, S_EXE, imm_EXE, freeze, flush,
    input  alu_res_MEM, rm_val_MEM, dest_MEM, WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM,
           status_ID, branch_address_IF, stall_EXE
  );

  modport slave (
    input  valid_EXE, pc_EXE, rn_val_EXE, rm_val_EXE, rs_val_EXE, signed_imm_24_EXE,
           shifter_operand_EXE, exe_cmd_EXE, dest_EXE, WB_EN_EXE, MEM_R_EN_EXE,
           MEM_W_EN_EXE, S_EXE, imm_EXE, freeze, flush,
    output alu_res_MEM, rm_val_MEM, dest_MEM, WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM,
           status_ID, branch_address_IF, stall_EXE
  );
endinterface

// File: rtl/exe_stage_mc_mul_iter.sv
// Iterative shift-and-add multiplier retiring MUL_STEP multiplier bits per cycle;
// the product is held in DONE until the downstream stage accepts it.
module mul_iter
  import exe_pkg::*;
#(
  parameter int unsigned DW       = 32,
  parameter int unsigned MUL_STEP = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          flush,
  input  logic          freeze,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] product
);
  localparam int unsigned N  = DW / MUL_STEP;
  localparam int unsigned CW = $clog2(N + 1);

  mul_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] mcand_q, mcand_d;
  logic [DW-1:0] mplier_q, mplier_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] partial;

  always_comb begin
    partial = '0;
    for (int unsigned i = 0; i < MUL_STEP; i++) begin
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    unique case (state_q)
      IDLE: if (start && !freeze) begin
        mcand_d  = a;
        mplier_d = b;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = BUSY;
      end
      BUSY: if (!freeze) begin
        acc_d    = acc_q + partial;
        mcand_d  = mcand_q << MUL_STEP;
        mplier_d = mplier_q >> MUL_STEP;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) state_d = DONE;
      end
      DONE: if (!freeze) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign busy    = (state_q == BUSY);
  assign done    = (state_q == DONE);
  assign product = acc_q;
endmodule

// File: rtl/exe_stage_mc.sv
// Execute stage: shifter, ALU, NZCV register, EXE/MEM register, branch target and
// the stall handshake around the iterative multiplier.
module exe_stage_mc
  import exe_pkg::*;
#(
  parameter int unsigned DW       = 32,
  parameter int unsigned MUL_STEP = 2
) (
  input logic          clk,
  input logic          rst,
  exe_stage_mc_if.slave bus
);
  localparam int unsigned SW = $clog2(DW);

  logic          is_mul, mul_busy, mul_done, mul_idle, commit;
  logic [DW-1:0] mul_product;
  logic [DW-1:0] val2, result, rot_src;
  logic [2*DW-1:0] rot_tmp;
  logic [SW-1:0] amt;
  logic [DW:0]   sum;
  logic [3:0]    flags, status_q, status_d;
  logic [DW-1:0] alu_res_q, alu_res_d, rm_val_q, rm_val_d;
  logic [3:0]    dest_q, dest_d;
  logic          wb_en_q, wb_en_d, mem_r_q, mem_r_d, mem_w_q, mem_w_d;

  assign is_mul = (bus.exe_cmd_EXE == CMD_MUL) || (bus.exe_cmd_EXE == CMD_MLA);

  mul_iter #(.DW(DW), .MUL_STEP(MUL_STEP)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (bus.valid_EXE && is_mul && !bus.flush),
    .flush   (bus.flush),
    .freeze  (bus.freeze),
    .a       (bus.rm_val_EXE),
    .b       (bus.rs_val_EXE),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign mul_idle      = !mul_busy && !mul_done;
  assign commit        = bus.valid_EXE && !bus.flush && (!is_mul || mul_done);
  assign bus.stall_EXE = bus.freeze ||
                         (!bus.flush && ((mul_idle && bus.valid_EXE && is_mul) || mul_busy));

  // Immediate and register rotates share one doubled-word right shift.
  always_comb begin
    rot_src = bus.rm_val_EXE;
    amt     = SW'(bus.shifter_operand_EXE[11:7]);
    if (bus.imm_EXE) begin
      rot_src = DW'(bus.shifter_operand_EXE[7:0]);
      amt     = SW'({bus.shifter_operand_EXE[11:8], 1'b0});
    end
    rot_tmp = {rot_src, rot_src} >> amt;
    val2    = rot_tmp[DW-1:0];
    if (bus.MEM_R_EN_EXE || bus.MEM_W_EN_EXE) begin
      val2 = DW'(bus.shifter_operand_EXE);
    end else if (!bus.imm_EXE) begin
      unique case (bus.shifter_operand_EXE[6:5])
        SH_LSL:  val2 = bus.rm_val_EXE << amt;
        SH_LSR:  val2 = bus.rm_val_EXE >> amt;
        SH_ASR:  val2 = DW'($signed(bus.rm_val_EXE) >>> amt);
        default: val2 = rot_tmp[DW-1:0];
      endcase
    end
  end

  always_comb begin
    sum    = '0;
    result = '0;
    flags  = status_q;
    unique case (bus.exe_cmd_EXE)
      CMD_MOV: result = val2;
      CMD_MVN: result = ~val2;
      CMD_ADD: sum = {1'b0, bus.rn_val_EXE} + {1'b0, val2};
      CMD_ADC: sum = {1'b0, bus.rn_val_EXE} + {1'b0, val2} + (DW+1)'(status_q[FLAG_C]);
      CMD_SUB: sum = {1'b0, bus.rn_val_EXE} + {1'b0, ~val2} + (DW+1)'(1);
      CMD_SBC: sum = {1'b0, bus.rn_val_EXE} + {1'b0, ~val2} + (DW+1)'(status_q[FLAG_C]);
      CMD_AND: result = bus.rn_val_EXE & val2;
      CMD_ORR: result = bus.rn_val_EXE | val2;
      CMD_EOR: result = bus.rn_val_EXE ^ val2;
      CMD_MUL: result = mul_product;
      CMD_MLA: result = mul_product + bus.rn_val_EXE;
      default: result = '0;
    endcase
    unique case (bus.exe_cmd_EXE)
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
        result        = sum[DW-1:0];
        flags[FLAG_C] = sum[DW];
        if (bus.exe_cmd_EXE == CMD_ADD || bus.exe_cmd_EXE == CMD_ADC)
          flags[FLAG_V] = (bus.rn_val_EXE[DW-1] == val2[DW-1]) &&
                          (result[DW-1] != bus.rn_val_EXE[DW-1]);
        else
          flags[FLAG_V] = (bus.rn_val_EXE[DW-1] != val2[DW-1]) &&
                          (result[DW-1] != bus.rn_val_EXE[DW-1]);
      end
      default: ;
    endcase
    if (bus.exe_cmd_EXE inside {CMD_MOV, CMD_MVN, CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC,
                                CMD_AND, CMD_ORR, CMD_EOR, CMD_MUL, CMD_MLA}) begin
      flags[FLAG_N] = result[DW-1];
      flags[FLAG_Z] = (result == '0);
    end
  end

  always_comb begin
    status_d  = status_q;
    alu_res_d = alu_res_q;
    rm_val_d  = rm_val_q;
    dest_d    = dest_q;
    wb_en_d   = wb_en_q;
    mem_r_d   = mem_r_q;
    mem_w_d   = mem_w_q;
    if (!bus.freeze) begin
      if (bus.S_EXE && commit) status_d = flags;
      alu_res_d = result;
      rm_val_d  = bus.rm_val_EXE;
      dest_d    = bus.dest_EXE;
      wb_en_d   = commit && bus.WB_EN_EXE;
      mem_r_d   = commit && bus.MEM_R_EN_EXE;
      mem_w_d   = commit && bus.MEM_W_EN_EXE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q  <= '0;
      alu_res_q <= '0;
      rm_val_q  <= '0;
      dest_q    <= '0;
      wb_en_q   <= 1'b0;
      mem_r_q   <= 1'b0;
      mem_w_q   <= 1'b0;
    end else begin
      status_q  <= status_d;
      alu_res_q <= alu_res_d;
      rm_val_q  <= rm_val_d;
      dest_q    <= dest_d;
      wb_en_q   <= wb_en_d;
      mem_r_q   <= mem_r_d;
      mem_w_q   <= mem_w_d;
    end
  end

  assign bus.status_ID    = status_q;
  assign bus.alu_res_MEM  = alu_res_q;
  assign bus.rm_val_MEM   = rm_val_q;
  assign bus.dest_MEM     = dest_q;
  assign bus.WB_EN_MEM    = wb_en_q;
  assign bus.MEM_R_EN_MEM = mem_r_q;
  assign bus.MEM_W_EN_MEM = mem_w_q;
  assign bus.branch_address_IF =
    bus.pc_EXE + DW'({{40{bus.signed_imm_24_EXE[23]}}, bus.signed_imm_24_EXE, 2'b00});
endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed bench for exe_stage_mc with DW=32, MUL_STEP=2 (N=16).
module tb_exe_stage_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  exe_stage_mc_if #(.DW(32)) bus ();

  exe_stage_mc #(.DW(32), .MUL_STEP(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    bus.valid_EXE = 1'b0; bus.pc_EXE = '0; bus.rn_val_EXE = '0; bus.rm_val_EXE = '0;
    bus.rs_val_EXE = '0; bus.signed_imm_24_EXE = '0; bus.shifter_operand_EXE = '0;
    bus.exe_cmd_EXE = '0; bus.dest_EXE = '0; bus.WB_EN_EXE = 1'b0; bus.MEM_R_EN_EXE = 1'b0;
    bus.MEM_W_EN_EXE = 1'b0; bus.S_EXE = 1'b0; bus.imm_EXE = 1'b0;
    bus.freeze = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic op(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                    input logic [11:0] so, input logic imm, input logic s);
    idle_in();
    bus.valid_EXE = 1'b1; bus.exe_cmd_EXE = cmd; bus.rn_val_EXE = rn; bus.rm_val_EXE = rm;
    bus.shifter_operand_EXE = so; bus.imm_EXE = imm; bus.S_EXE = s;
    bus.WB_EN_EXE = 1'b1; bus.dest_EXE = 4'd3;
  endtask

  initial begin
    // reset with random inputs
    bus.valid_EXE = 1'($urandom); bus.pc_EXE = $urandom; bus.rn_val_EXE = $urandom;
    bus.rm_val_EXE = $urandom; bus.rs_val_EXE = $urandom; bus.signed_imm_24_EXE = 24'($urandom);
    bus.shifter_operand_EXE = 12'($urandom); bus.exe_cmd_EXE = 4'($urandom);
    bus.dest_EXE = 4'($urandom); bus.WB_EN_EXE = 1'b1; bus.MEM_R_EN_EXE = 1'b1;
    bus.MEM_W_EN_EXE = 1'b1; bus.S_EXE = 1'b1; bus.imm_EXE = 1'($urandom);
    bus.freeze = 1'($urandom); bus.flush = 1'($urandom);
    tick(); tick();
    check("rst_alu",    64'(bus.alu_res_MEM), 64'h0);
    check("rst_rm",     64'(bus.rm_val_MEM), 64'h0);
    check("rst_dest",   64'(bus.dest_MEM), 64'h0);
    check("rst_en",     64'({bus.WB_EN_MEM, bus.MEM_R_EN_MEM, bus.MEM_W_EN_MEM}), 64'h0);
    check("rst_status", 64'(bus.status_ID), 64'h0);
    idle_in();
    #1;
    check("rst_stall", 64'(bus.stall_EXE), 64'h0);
    rst = 1'b0;

    // SUB 5-5, S=1 -> Z,C
    op(4'b0100, 32'd5, 32'd5, 12'h000, 1'b0, 1'b1);
    tick();
    check("sub_res",    64'(bus.alu_res_MEM), 64'h0);
    check("sub_nzcv",   64'(bus.status_ID), 64'h6);
    check("sub_wb",     64'({bus.WB_EN_MEM, bus.dest_MEM}), 64'h13);

    // ADC with C=1: 0x7FFFFFFF + 0 + 1
    op(4'b0011, 32'h7FFF_FFFF, 32'h0, 12'h000, 1'b0, 1'b1);
    tick();
    check("adc_res",  64'(bus.alu_res_MEM), 64'h8000_0000);
    check("adc_nzcv", 64'(bus.status_ID), 64'h9);

    // MOV immediate 0x4FF -> 0xFF000000, S=0
    op(4'b0001, 32'h0, 32'h1234_5678, 12'h4FF, 1'b1, 1'b0);
    tick();
    check("imm_rot",   64'(bus.alu_res_MEM), 64'hFF00_0000);
    check("imm_keepf", 64'(bus.status_ID), 64'h9);

    // LDR address: Rn + zero-extended 0xFFF
    op(4'b0010, 32'h100, 32'hFFFF_FFFF, 12'hFFF, 1'b1, 1'b0);
    bus.MEM_R_EN_EXE = 1'b1;
    tick();
    check("ldr_addr", 64'(bus.alu_res_MEM), 64'h10FF);
    check("ldr_ren",  64'(bus.MEM_R_EN_MEM), 64'h1);

    // ASR #1 and ROR #4
    op(4'b0001, 32'h0, 32'h8000_0001, 12'h0C0, 1'b0, 1'b0);
    tick();
    check("asr1", 64'(bus.alu_res_MEM), 64'hC000_0000);
    op(4'b0001, 32'h0, 32'h0000_000F, 12'h260, 1'b0, 1'b0);
    tick();
    check("ror4", 64'(bus.alu_res_MEM), 64'hF000_0000);

    // undefined command with S=1: result 0, flags kept
    op(4'b0000, 32'h5, 32'h5, 12'h000, 1'b0, 1'b1);
    tick();
    check("undef_res",  64'(bus.alu_res_MEM), 64'h0);
    check("undef_nzcv", 64'(bus.status_ID), 64'h9);

    // branch target: 0x1000 + (-2 << 2)
    idle_in();
    bus.pc_EXE = 32'h1000; bus.signed_imm_24_EXE = 24'hFFFFFE;
    #1;
    check("branch", 64'(bus.branch_address_IF), 64'h0FF8);

    // freeze holds EXE/MEM
    op(4'b0010, 32'h1, 32'h1, 12'h000, 1'b0, 1'b1);
    bus.freeze = 1'b1;
    tick();
    check("frz_hold",   64'(bus.alu_res_MEM), 64'h0);
    check("frz_status", 64'(bus.status_ID), 64'h9);

    // MLA 7*9+3, S=1: stall 17 cycles, result after cycle 18, C/V kept (0,1)
    op(4'b1011, 32'd3, 32'd7, 12'h000, 1'b0, 1'b1);
    bus.rs_val_EXE = 32'd9; bus.dest_EXE = 4'd5;
    for (int i = 0; i < 17; i++) begin
      #1;
      check("mla_stall", 64'(bus.stall_EXE), 64'h1);
      tick();
      check("mla_bubble", 64'(bus.WB_EN_MEM), 64'h0);
    end
    check("mla_done_nostall", 64'(bus.stall_EXE), 64'h0);
    tick();
    check("mla_res",  64'(bus.alu_res_MEM), 64'd66);
    check("mla_wb",   64'({bus.WB_EN_MEM, bus.dest_MEM}), 64'h15);
    check("mla_nzcv", 64'(bus.status_ID), 64'h1);
    idle_in();
    tick();
    check("mla_once", 64'(bus.WB_EN_MEM), 64'h0);

    // MUL flushed on 5th BUSY cycle
    op(4'b1010, 32'h0, 32'd3, 12'h000, 1'b0, 1'b1);
    bus.rs_val_EXE = 32'd4;
    tick();
    for (int i = 0; i < 4; i++) tick();
    check("fl_busy_stall", 64'(bus.stall_EXE), 64'h1);
    bus.flush = 1'b1;
    #1;
    check("fl_stall_drop", 64'(bus.stall_EXE), 64'h0);
    tick();
    check("fl_bubble", 64'(bus.WB_EN_MEM), 64'h0);
    check("fl_status", 64'(bus.status_ID), 64'h1);
    idle_in();
    #1;
    check("fl_idle", 64'(bus.stall_EXE), 64'h0);
    tick();

    // MUL 6*7 with 3 freeze cycles in DONE
    op(4'b1010, 32'h0, 32'd6, 12'h000, 1'b0, 1'b0);
    bus.rs_val_EXE = 32'd7; bus.dest_EXE = 4'd2;
    for (int i = 0; i < 17; i++) tick();
    check("fz_done_nostall", 64'(bus.stall_EXE), 64'h0);
    bus.freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("fz_stall", 64'(bus.stall_EXE), 64'h1);
      tick();
      check("fz_hold", 64'(bus.WB_EN_MEM), 64'h0);
    end
    bus.freeze = 1'b0;
    #1;
    check("fz_release", 64'(bus.stall_EXE), 64'h0);
    tick();
    check("fz_res", 64'(bus.alu_res_MEM), 64'd42);
    check("fz_wb",  64'({bus.WB_EN_MEM, bus.dest_MEM}), 64'h12);
    idle_in();
    tick();
    check("fz_once", 64'(bus.WB_EN_MEM), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exe_stage_mc.md
# exe_stage_mc

Parametrised execute stage for the ARM-style pipeline: single-cycle ALU and shifter, plus an iterative multi-cycle multiplier (MUL/MLA) with a stall handshake. It owns the NZCV status register and the EXE/MEM pipeline register, and computes the branch target. It sits between the ID/EXE register and the memory stage. It honours a downstream freeze and a branch flush.

## Interface
- DW, 32, datapath width; legal values 16, 32, 64.
- MUL_STEP, 2, multiplier bits retired per cycle; must divide DW; N = DW/MUL_STEP.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_EXE  in  1  the EXE inputs hold a real instruction.
- pc_EXE, rn_val_EXE, rm_val_EXE, rs_val_EXE  in  DW each  PC+4, Rn, Rm, Rs (multiplier operand).
- signed_imm_24_EXE  in  24  branch offset in words.
- shifter_operand_EXE  in  12  immediate or shift field.
- exe_cmd_EXE  in  4  ALU command.
- dest_EXE  in  4  destination register.
- WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN_EXE, S_EXE, imm_EXE  in  1 each  control bits.
- freeze  in  1  downstream wait; hold the EXE/MEM register.
- flush  in  1  branch taken; kill the EXE instruction.
- alu_res_MEM, rm_val_MEM  out  DW  registered result and store data.
- dest_MEM  out  4; WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM  out  1 each  registered.
- status_ID  out  4  registered NZCV.
- branch_address_IF  out  DW  combinational branch target.
- stall_EXE  out  1  combinational; upstream must hold the ID/EXE register.

## Operation
- exe_cmd encodings:
  - MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000.
  - MUL 1010 (Rm*Rs), MLA 1011 (Rn + Rm*Rs), low DW bits.
  - Any other code yields result 0 and leaves the flags unchanged.
- Val2 selection:
  - Memory access (MEM_R_EN_EXE or MEM_W_EN_EXE): zero-extended shifter_operand[11:0].
  - imm_EXE: zero-extended imm8 = [7:0], rotated right by 2*[11:8] within DW.
  - Otherwise: Rm shifted by shift_imm [11:7], type [6:5] (LSL, LSR, ASR, ROR). Shift amount is taken mod DW.
- Flags, full-DW arithmetic:
  - N = result MSB; Z = result == 0.
  - ADD/ADC: C = carry out of bit DW-1.
  - SUB/SBC: C = NOT borrow. SBC computes Rn - Val2 - !C.
  - ADD/ADC/SUB/SBC: V = signed overflow.
  - Logical ops and MUL/MLA: C and V are preserved.
- Status register commit: loads on S_EXE & valid_EXE & result-commit & !freeze & !flush.
- branch_address_IF = pc_EXE + (sign-extend(signed_imm_24_EXE) << 2), computed at DW width.
- Multiplier FSM states:
  - IDLE: when valid & MUL/MLA & !flush, latch operands, clear count, go to BUSY.
  - BUSY: retire MUL_STEP bits per cycle using an accumulator. After step N-1, go to DONE.
  - DONE: result (plus Rn for MLA) is presented. Go to IDLE when !freeze; hold DONE while freeze.
  - Abort: flush in any state forces IDLE without commit.
- stall_EXE = freeze | (!flush & ((IDLE & valid & MUL/MLA) | BUSY)).
- EXE/MEM register update priority:
  - freeze: hold.
  - flush, or !valid_EXE, or multiplier not in DONE for a MUL/MLA: load a bubble (enables 0, data don't-care).
  - Otherwise: load the result.
- Reset: all outputs registered by this block go to 0, status_ID = 0000, FSM = IDLE. A reset during BUSY aborts the multiply.

## Timing
- ALU and shifter ops: inputs in cycle t; results in the MEM outputs after the edge ending cycle t.
- MUL/MLA accepted in cycle t (IDLE):
  - stall_EXE is high in cycles t..t+N; BUSY spans t+1..t+N.
  - DONE is cycle t+N+1 with stall low; the result is registered at the end of t+N+1.
  - Total occupancy is N+2 cycles; N = 16 for the default parameters.
- freeze: adds exactly one hold cycle per asserted cycle at any point. Nothing is lost or duplicated.
- flush and freeze together: the EXE/MEM register holds, the FSM goes to IDLE, and status is not updated.
- Back-to-back MULs: the second is accepted in the cycle after DONE.

## Structure
- Package exe_pkg holds:
  - The exe_cmd localparams.
  - The shift-type constants.
  - The NZCV bit indices (N=3, Z=2, C=1, V=0).
  - The FSM enum mul_state_t (IDLE, BUSY, DONE).
- Sub-module mul_iter (parametrised DW, MUL_STEP) contains the FSM, counter and accumulator. It has a start/flush/freeze in, and a busy/done/product out.
- ALU, shifter, status register and pipeline register stay in exe_stage_mc.

## Test plan
All tests use DW=32 and MUL_STEP=2.
- Reset: assert rst with random inputs. All MEM outputs are 0, status_ID = 0, and stall_EXE is 0 with valid low.
- SUB S=1: Rn=5, Rm=5. alu_res_MEM=0 and status_ID=0110 (Z,C) next cycle.
- ADC S=1: C=1, Rn=0x7FFFFFFF, Val2=0. Result 0x80000000, NZCV=1001.
- Immediate rotate: imm_EXE with field 0x4FF gives Val2 0xFF000000. LDR with field 0xFFF gives Val2 0x00000FFF.
- MLA 7*9+3: stall_EXE high 17 cycles, alu_res_MEM=66 after cycle 18. With S=1 the flags are N=0, Z=0, and C/V are unchanged.
- Interrupted MUL:
  - flush on cycle 5 of BUSY: a bubble is registered, stall drops that cycle, status is unchanged.
  - freeze for 3 cycles during DONE: the result is registered 3 cycles late, exactly once.
